// File: rtl/pp_param_ctrl.sv
// pp_param_ctrl: frame-synchronous sequencer for the post-processing datapath
// controls (inversion enable, shift, gain). New settings arrive via a
// valid/ready handshake into a one-deep pending register. They are committed
// on the next vsync edge and then ramp toward the target one step per frame.
// Optional build macro PP_CTRL_INV_FADE_EN: an inversion change fades gain
// down to zero, flips inversion at zero and ramps back up, instead of
// switching inversion abruptly on the commit frame.
module pp_param_ctrl #(
    parameter int unsigned STEP_G   = 1024,
    parameter int unsigned STEP_S   = 4,
    parameter int unsigned GAIN_RST = 32768,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic        vin_clk_i,
    input  logic        rst_i,
    input  logic        vin_vs_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic        cfg_inv_i,
    input  logic [8:0]  cfg_shift_i,
    input  logic [17:0] cfg_gain_i,
    output logic        inv_en_o,
    output logic [29:0] shift_o,
    output logic [17:0] gain_o,
    output logic        busy_o
);

`ifdef PP_CTRL_INV_FADE_EN
    typedef enum logic [1:0] {IDLE, RAMP, FADE_OUT, FADE_IN} state_t;
`else
    typedef enum logic [1:0] {IDLE, RAMP} state_t;
`endif

    localparam logic signed [18:0] STEP_G_W = 19'(STEP_G);
    localparam logic signed [9:0]  STEP_S_W = 10'(STEP_S);

    state_t      state;
    state_t      state_nx;

    logic        vs_q;
    logic        fe;
    logic        accept;
    logic        commit;

    logic        pend_full;
    logic        pend_full_nx;
    logic        pend_inv;
    logic [8:0]  pend_shift;
    logic [17:0] pend_gain;

    logic        tgt_inv;
    logic [8:0]  tgt_shift;
    logic [17:0] tgt_gain;

    logic        nt_inv;
    logic [8:0]  nt_shift;
    logic [17:0] nt_gain;

    logic        inv_en;
    logic        inv_nx;
    logic [8:0]  shift;
    logic [8:0]  shift_nx;
    logic [17:0] gain;
    logic [17:0] gain_nx;
    logic        ready;
    logic        busy;

    logic signed [18:0] gain_diff;
    logic signed [9:0]  shift_diff;
    logic [17:0]        ramp_gain;
    logic [8:0]         ramp_shift;
    logic               ramp_done;

`ifdef PP_CTRL_INV_FADE_EN
    logic [17:0] fade_gain;
    logic        do_fade;
`endif

    // Frame edge is the transition of vsync into its active level.
    assign fe     = (vin_vs_i == VS_POL) && (vs_q != VS_POL);
    assign accept = cfg_valid_i && ready;
    assign commit = fe && pend_full;

    // The target seen by this frame's step: freshly committed values take effect immediately.
    always_comb begin
        nt_inv   = tgt_inv;
        nt_shift = tgt_shift;
        nt_gain  = tgt_gain;
        if (commit) begin
            nt_inv   = pend_inv;
            nt_shift = pend_shift;
            nt_gain  = pend_gain;
        end
    end

    // One bounded ramp step toward the target; differences are one bit wider so they never wrap.
    always_comb begin
        gain_diff  = $signed({1'b0, nt_gain}) - $signed({1'b0, gain});
        shift_diff = $signed({nt_shift[8], nt_shift}) - $signed({shift[8], shift});
        ramp_gain  = nt_gain;
        ramp_shift = nt_shift;
        if (gain_diff > STEP_G_W) begin
            ramp_gain = gain + 18'(STEP_G);
        end else if (gain_diff < -STEP_G_W) begin
            ramp_gain = gain - 18'(STEP_G);
        end
        if (shift_diff > STEP_S_W) begin
            ramp_shift = shift + 9'(STEP_S);
        end else if (shift_diff < -STEP_S_W) begin
            ramp_shift = shift - 9'(STEP_S);
        end
        ramp_done = (ramp_gain == nt_gain) && (ramp_shift == nt_shift);
    end

`ifdef PP_CTRL_INV_FADE_EN
    // Fade-out step: gain falls toward zero without undershooting.
    always_comb begin
        fade_gain = '0;
        if (gain > 18'(STEP_G)) begin
            fade_gain = gain - 18'(STEP_G);
        end
        do_fade = (state == FADE_OUT) || (commit && (pend_inv != inv_en));
    end
`endif

    // Next control values and state; everything holds except on a frame edge.
    always_comb begin
        state_nx = state;
        gain_nx  = gain;
        shift_nx = shift;
        inv_nx   = inv_en;
        if (fe) begin
`ifdef PP_CTRL_INV_FADE_EN
            if (do_fade) begin
                gain_nx = fade_gain;
                if (fade_gain == '0) begin
                    inv_nx   = nt_inv;
                    state_nx = FADE_IN;
                end else begin
                    state_nx = FADE_OUT;
                end
            end else if (commit || (state != IDLE)) begin
                gain_nx  = ramp_gain;
                shift_nx = ramp_shift;
                if (ramp_done) begin
                    state_nx = IDLE;
                end else if (state == FADE_IN) begin
                    state_nx = FADE_IN;
                end else begin
                    state_nx = RAMP;
                end
            end
`else
            if (commit || (state != IDLE)) begin
                gain_nx  = ramp_gain;
                shift_nx = ramp_shift;
                inv_nx   = nt_inv;
                state_nx = ramp_done ? IDLE : RAMP;
            end
`endif
        end
    end

    // Pending slot fills on a handshake and empties when it is committed.
    always_comb begin
        pend_full_nx = pend_full;
        if (accept) begin
            pend_full_nx = 1'b1;
        end else if (commit) begin
            pend_full_nx = 1'b0;
        end
    end

    // All state and registered outputs; reset abandons any ramp or pending setting.
    always_ff @(posedge vin_clk_i) begin
        if (rst_i) begin
            vs_q       <= VS_POL;
            state      <= IDLE;
            pend_full  <= 1'b0;
            pend_inv   <= 1'b0;
            pend_shift <= '0;
            pend_gain  <= '0;
            tgt_inv    <= 1'b0;
            tgt_shift  <= '0;
            tgt_gain   <= 18'(GAIN_RST);
            inv_en     <= 1'b0;
            shift      <= '0;
            gain       <= 18'(GAIN_RST);
            ready      <= 1'b1;
            busy       <= 1'b0;
        end else begin
            vs_q      <= vin_vs_i;
            pend_full <= pend_full_nx;
            if (accept) begin
                pend_inv   <= cfg_inv_i;
                pend_shift <= cfg_shift_i;
                pend_gain  <= cfg_gain_i;
            end
            if (commit) begin
                tgt_inv   <= pend_inv;
                tgt_shift <= pend_shift;
                tgt_gain  <= pend_gain;
            end
            state  <= state_nx;
            inv_en <= inv_nx;
            shift  <= shift_nx;
            gain   <= gain_nx;
            ready  <= ~pend_full_nx;
            busy   <= (state_nx != IDLE) || pend_full_nx;
        end
    end

    assign cfg_ready_o = ready;
    assign inv_en_o    = inv_en;
    assign shift_o     = {{21{shift[8]}}, shift};
    assign gain_o      = gain;
    assign busy_o      = busy;

endmodule

// File: tb/tb_pp_param_ctrl.sv
// tb_pp_param_ctrl: directed self-checking bench for pp_param_ctrl with
// default parameters (STEP_G=1024, STEP_S=4, GAIN_RST=32768, VS_POL=1).
// Inversion expectations follow the PP_CTRL_INV_FADE_EN build setting.
module tb_pp_param_ctrl;

    logic        vin_clk;
    logic        rst;
    logic        vin_vs;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_inv;
    logic [8:0]  cfg_shift;
    logic [17:0] cfg_gain;
    logic        inv_en;
    logic [29:0] shift;
    logic [17:0] gain;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    pp_param_ctrl dut (
        .vin_clk_i   (vin_clk),
        .rst_i       (rst),
        .vin_vs_i    (vin_vs),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_inv_i   (cfg_inv),
        .cfg_shift_i (cfg_shift),
        .cfg_gain_i  (cfg_gain),
        .inv_en_o    (inv_en),
        .shift_o     (shift),
        .gain_o      (gain),
        .busy_o      (busy)
    );

    // Free-running pixel clock.
    initial vin_clk = 1'b0;
    always #5 vin_clk = ~vin_clk;

    // Advance n clocks and settle 1 time unit past the rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge vin_clk);
            #1;
        end
    endtask

    // Drive the configuration handshake inputs.
    task automatic applyStimulus(input logic valid, input logic inv,
                                 input logic [8:0] sh, input logic [17:0] gn);
        cfg_valid = valid;
        cfg_inv   = inv;
        cfg_shift = sh;
        cfg_gain  = gn;
    endtask

    // Single comparison with failure accounting.
    task automatic checkField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against hand-computed values.
    task automatic checkOutput(input string tag, input logic e_inv, input logic [29:0] e_shift,
                               input logic [17:0] e_gain, input logic e_ready, input logic e_busy);
        checkField({tag, ".inv"},   {31'd0, inv_en},    {31'd0, e_inv});
        checkField({tag, ".shift"}, {2'd0, shift},      {2'd0, e_shift});
        checkField({tag, ".gain"},  {14'd0, gain},      {14'd0, e_gain});
        checkField({tag, ".ready"}, {31'd0, cfg_ready}, {31'd0, e_ready});
        checkField({tag, ".busy"},  {31'd0, busy},      {31'd0, e_busy});
    endtask

    // One vsync pulse: one cycle active, then two inactive.
    task automatic frameEdge();
        vin_vs = 1'b1;
        tick(1);
        vin_vs = 1'b0;
        tick(2);
    endtask

    // Directed sequence.
    initial begin
        rst    = 1'b1;
        vin_vs = 1'b0;
        applyStimulus(1'b0, 1'b0, 9'd0, 18'd0);
        tick(3);
        rst = 1'b0;
        checkOutput("reset", 1'b0, 30'd0, 18'd32768, 1'b1, 1'b0);
        tick(1);

        $display("[TB] basic ramp");
        applyStimulus(1'b1, 1'b0, 9'd8, 18'd36864);
        tick(1);
        applyStimulus(1'b0, 1'b0, 9'd0, 18'd0);
        checkOutput("accepted", 1'b0, 30'd0, 18'd32768, 1'b0, 1'b1);
        tick(3);
        checkOutput("hold_no_vs", 1'b0, 30'd0, 18'd32768, 1'b0, 1'b1);
        vin_vs = 1'b1;
        checkField("fe_cycle.gain", {14'd0, gain}, {14'd0, 18'd32768});
        tick(1);
        checkOutput("edge1", 1'b0, 30'd4, 18'd33792, 1'b1, 1'b1);
        vin_vs = 1'b0;
        tick(2);
        checkOutput("edge1_hold", 1'b0, 30'd4, 18'd33792, 1'b1, 1'b1);
        frameEdge();
        checkOutput("edge2", 1'b0, 30'd8, 18'd34816, 1'b1, 1'b1);
        frameEdge();
        checkOutput("edge3", 1'b0, 30'd8, 18'd35840, 1'b1, 1'b1);
        frameEdge();
        checkOutput("edge4", 1'b0, 30'd8, 18'd36864, 1'b1, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 1'b0, 9'd8, 18'd35840);
        tick(1);
        applyStimulus(1'b1, 1'b0, 9'd0, 18'd34816);
        tick(2);
        checkOutput("bp_blocked", 1'b0, 30'd8, 18'd36864, 1'b0, 1'b1);
        vin_vs = 1'b1;
        tick(1);
        checkOutput("bp_commit_a", 1'b0, 30'd8, 18'd35840, 1'b1, 1'b0);
        vin_vs = 1'b0;
        tick(1);
        checkOutput("bp_accept_b", 1'b0, 30'd8, 18'd35840, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 9'd0, 18'd0);
        frameEdge();
        checkOutput("bp_commit_b", 1'b0, 30'd4, 18'd34816, 1'b1, 1'b1);
        frameEdge();
        checkOutput("bp_done_b", 1'b0, 30'd0, 18'd34816, 1'b1, 1'b0);

        $display("[TB] simultaneous accept and frame edge");
        applyStimulus(1'b1, 1'b0, 9'd0, 18'd33792);
        vin_vs = 1'b1;
        tick(1);
        checkOutput("simul_no_commit", 1'b0, 30'd0, 18'd34816, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 9'd0, 18'd0);
        vin_vs = 1'b0;
        tick(1);
        frameEdge();
        checkOutput("simul_next_fe", 1'b0, 30'd0, 18'd33792, 1'b1, 1'b0);

        $display("[TB] negative shift and reset mid-ramp");
        applyStimulus(1'b1, 1'b0, 9'h1FD, 18'd33792);
        tick(1);
        applyStimulus(1'b0, 1'b0, 9'd0, 18'd0);
        frameEdge();
        checkOutput("neg_shift", 1'b0, 30'h3FFFFFFD, 18'd33792, 1'b1, 1'b0);
        frameEdge();
        checkOutput("neg_shift_hold", 1'b0, 30'h3FFFFFFD, 18'd33792, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 9'd8, 18'd36864);
        tick(1);
        applyStimulus(1'b0, 1'b0, 9'd0, 18'd0);
        frameEdge();
        checkOutput("midramp", 1'b0, 30'd1, 18'd34816, 1'b1, 1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("midramp_reset", 1'b0, 30'd0, 18'd32768, 1'b1, 1'b0);
        tick(1);
        frameEdge();
        checkOutput("after_reset_fe", 1'b0, 30'd0, 18'd32768, 1'b1, 1'b0);

        $display("[TB] long ramp down to 2048");
        applyStimulus(1'b1, 1'b0, 9'd0, 18'd2048);
        tick(1);
        applyStimulus(1'b0, 1'b0, 9'd0, 18'd0);
        for (int i = 0; i < 15; i++) frameEdge();
        checkOutput("ramp_down_mid", 1'b0, 30'd0, 18'd17408, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) frameEdge();
        checkOutput("ramp_down_end", 1'b0, 30'd0, 18'd2048, 1'b1, 1'b0);

        $display("[TB] inversion change");
        applyStimulus(1'b1, 1'b1, 9'd0, 18'd2048);
        tick(1);
        applyStimulus(1'b0, 1'b0, 9'd0, 18'd0);
`ifdef PP_CTRL_INV_FADE_EN
        frameEdge();
        checkOutput("fade_out1", 1'b0, 30'd0, 18'd1024, 1'b1, 1'b1);
        frameEdge();
        checkOutput("fade_zero_flip", 1'b1, 30'd0, 18'd0, 1'b1, 1'b1);
        frameEdge();
        checkOutput("fade_in1", 1'b1, 30'd0, 18'd1024, 1'b1, 1'b1);
        frameEdge();
        checkOutput("fade_in_done", 1'b1, 30'd0, 18'd2048, 1'b1, 1'b0);
`else
        tick(2);
        checkOutput("inv_before_fe", 1'b0, 30'd0, 18'd2048, 1'b0, 1'b1);
        frameEdge();
        checkOutput("inv_flip", 1'b1, 30'd0, 18'd2048, 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
